// File: rtl/traffic_phase_scheduler_pkg.sv
// rtl/traffic_phase_scheduler_pkg.sv - shared phase codes, config addresses and default durations
package traffic_pkg;

  // Codes must match the downstream light decoder.
  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    CG = 2'b10,
    CY = 2'b11
  } phase_e;

  localparam logic [1:0] CFG_COUNTRY = 2'd0;
  localparam logic [1:0] CFG_YELLOW  = 2'd1;
  localparam logic [1:0] CFG_MINHWY  = 2'd2;
  localparam logic [1:0] CFG_WALK    = 2'd3;

  localparam int DEF_TW      = 4;
  localparam int DEF_COUNTRY = 8;
  localparam int DEF_YELLOW  = 3;
  localparam int DEF_MINHWY  = 5;
  localparam int DEF_WALK    = 6;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - configuration write bus between software and scheduler
interface traffic_phase_scheduler_if #(
  parameter int TW = 4
);
  logic          cfg_valid;
  logic [1:0]    cfg_addr;
  logic [TW-1:0] cfg_data;
  logic          cfg_ready;

  modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/traffic_phase_scheduler_timer.sv
// rtl/traffic_phase_scheduler_timer.sv - loadable tick-enabled saturating down-counter
module phase_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          tick_i,
  output logic [TW-1:0] count_o,
  output logic          done_o
);
  logic [TW-1:0] cnt_q, cnt_d;

  // A load wins over the tick so every phase starts from its full duration.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == '0);
endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - intersection phase FSM with pedestrian latch, emergency preempt
// and programmable durations
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TW          = DEF_TW,
  parameter int RST_COUNTRY = DEF_COUNTRY,
  parameter int RST_YELLOW  = DEF_YELLOW,
  parameter int RST_MINHWY  = DEF_MINHWY,
  parameter int RST_WALK    = DEF_WALK
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       car_sync,
  input  logic                       ped_req,
  input  logic                       emerg_req,
  traffic_phase_scheduler_if.slave   cfg,
  output logic [1:0]                 traffic_state,
  output logic                       walk,
  output logic                       emerg_active,
  output logic [TW-1:0]              remaining
);
  phase_e        state_q, state_d;
  logic [TW-1:0] country_q, yellow_q, minhwy_q, walkdur_q;
  logic          walk_q, walk_d;
  logic          ped_q, ped_d;
  logic          emerg_q;
  logic          load;
  logic [TW-1:0] load_val;
  logic          done;
  logic          served;
  logic          cfg_we;

  assign cfg.cfg_ready = (state_q == HG) || (state_q == CG);
  assign cfg_we        = cfg.cfg_valid & cfg.cfg_ready;
  // A button press landing on the CG entry edge is served by that entry.
  assign served        = ped_q | ped_req;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = minhwy_q;
    walk_d   = walk_q;
    ped_d    = ped_q | ped_req;
    case (state_q)
      HG: if (done && !emerg_q && (car_sync || ped_q)) begin
        state_d  = HY;
        load     = 1'b1;
        load_val = yellow_q;
      end
      HY: if (done) begin
        load = 1'b1;
        if (emerg_q) begin
          state_d  = HG;
          load_val = minhwy_q;
        end else begin
          state_d  = CG;
          load_val = (served && (walkdur_q > country_q)) ? walkdur_q : country_q;
          walk_d   = served;
          ped_d    = 1'b0;
        end
      end
      CG: if (done || emerg_q) begin
        state_d  = CY;
        load     = 1'b1;
        load_val = yellow_q;
        walk_d   = 1'b0;
      end
      CY: if (done) begin
        state_d  = HG;
        load     = 1'b1;
        load_val = minhwy_q;
      end
      default: state_d = HG;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HG;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      walk_q  <= 1'b0;
      ped_q   <= 1'b0;
      emerg_q <= 1'b0;
    end else begin
      walk_q  <= walk_d;
      ped_q   <= ped_d;
      emerg_q <= emerg_req;
    end
  end

  // Loads above read the pre-edge values, so a write only affects later phases.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      country_q <= TW'(RST_COUNTRY);
      yellow_q  <= TW'(RST_YELLOW);
      minhwy_q  <= TW'(RST_MINHWY);
      walkdur_q <= TW'(RST_WALK);
    end else if (cfg_we) begin
      case (cfg.cfg_addr)
        CFG_COUNTRY: country_q <= cfg.cfg_data;
        CFG_YELLOW:  yellow_q  <= cfg.cfg_data;
        CFG_MINHWY:  minhwy_q  <= cfg.cfg_data;
        default:     walkdur_q <= cfg.cfg_data;
      endcase
    end
  end

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(RST_MINHWY))
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_i     (tick),
    .count_o    (remaining),
    .done_o     (done)
  );

  assign traffic_state = state_q;
  assign walk          = walk_q;
  assign emerg_active  = emerg_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed and random checks of the phase scheduler against a reference model
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  logic       clock, reset, tick, car_sync, ped_req, emerg_req;
  logic [1:0] traffic_state;
  logic       walk, emerg_active;
  logic [3:0] remaining;
  int         n_cmp, n_fail, n;

  traffic_phase_scheduler_if #(.TW(4)) cif ();

  traffic_phase_scheduler #(.TW(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .car_sync      (car_sync),
    .ped_req       (ped_req),
    .emerg_req     (emerg_req),
    .cfg           (cif),
    .traffic_state (traffic_state),
    .walk          (walk),
    .emerg_active  (emerg_active),
    .remaining     (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: phase, ticks left, lamp, pending button, emergency, durations.
  phase_e m_ph;
  int     m_cnt, m_walk, m_ped, m_em;
  int     m_cfg[4];

  task automatic model_reset();
    m_ph = HG; m_cnt = 5; m_walk = 0; m_ped = 0; m_em = 0;
    m_cfg = '{8, 3, 5, 6};
  endtask

  task automatic model_edge();
    phase_e nph;
    int     ncnt, nwalk, nped, srv;
    bit     elapsed, accept;
    elapsed = (m_cnt == 0);
    accept  = (m_ph == HG) || (m_ph == CG);
    nph     = m_ph;
    nwalk   = m_walk;
    nped    = m_ped | int'(ped_req);
    ncnt    = (tick && m_cnt > 0) ? m_cnt - 1 : m_cnt;
    if (m_ph == HG && elapsed && m_em == 0 && (car_sync || m_ped != 0)) begin
      nph = HY; ncnt = m_cfg[1];
    end else if (m_ph == HY && elapsed && m_em != 0) begin
      nph = HG; ncnt = m_cfg[2];
    end else if (m_ph == HY && elapsed) begin
      srv   = (m_ped != 0 || ped_req) ? 1 : 0;
      nph   = CG; nped = 0; nwalk = srv;
      ncnt  = (srv != 0 && m_cfg[3] > m_cfg[0]) ? m_cfg[3] : m_cfg[0];
    end else if (m_ph == CG && (elapsed || m_em != 0)) begin
      nph = CY; ncnt = m_cfg[1]; nwalk = 0;
    end else if (m_ph == CY && elapsed) begin
      nph = HG; ncnt = m_cfg[2];
    end
    if (cif.cfg_valid && accept) m_cfg[cif.cfg_addr] = int'(cif.cfg_data);
    m_ph = nph; m_cnt = ncnt; m_walk = nwalk; m_ped = nped; m_em = int'(emerg_req);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(traffic_state), 32'(m_ph));
    chk("remaining", 32'(remaining), 32'(m_cnt));
    chk("walk", 32'(walk), 32'(m_walk));
    chk("emerg_active", 32'(emerg_active), 32'(m_em));
    chk("cfg_ready", 32'(cif.cfg_ready), (m_ph == HG || m_ph == CG) ? 32'd1 : 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic count_phase(input phase_e ph, output int cycles);
    cycles = 0;
    while (traffic_state == ph && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic wait_phase(input string tag, input phase_e ph, input int budget);
    int i;
    i = 0;
    while (traffic_state != ph && i < budget) begin
      step();
      i++;
    end
    chk(tag, 32'(traffic_state), 32'(ph));
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; tick = 1'b0; car_sync = 1'b0; ped_req = 1'b0; emerg_req = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_addr = 2'd0; cif.cfg_data = 4'd0;
    model_reset();
    #12;
    compare_all();
    chk("rst_remaining", 32'(remaining), 32'd5);
    @(negedge clock);
    reset = 1'b1;

    // Default cycle with a waiting car: HG 5, HY 3, CG 8, CY 3 ticks.
    tick = 1'b1; car_sync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("hg_countdown", 32'(remaining), 32'(5 - i));
      step();
    end
    chk("enter_hy", 32'(traffic_state), 32'(HY));
    count_phase(HY, n); chk("hy_len", 32'(n), 32'd4);
    count_phase(CG, n); chk("cg_len", 32'(n), 32'd9);
    count_phase(CY, n); chk("cy_len", 32'(n), 32'd4);
    chk("back_hg", 32'(traffic_state), 32'(HG));

    // Lone pedestrian after minimum green.
    car_sync = 1'b0;
    repeat (8) step();
    chk("hg_hold_no_req", 32'(traffic_state), 32'(HG));
    pulse_ped();
    step();
    chk("ped_to_hy", 32'(traffic_state), 32'(HY));
    count_phase(HY, n);
    chk("walk_at_cg", 32'(walk), 32'd1);
    count_phase(CG, n); chk("ped_cg_len", 32'(n), 32'd9);
    chk("walk_off_cy", 32'(walk), 32'd0);
    count_phase(CY, n);
    repeat (12) step();
    chk("ped_cleared", 32'(traffic_state), 32'(HG));

    // Longer walk, plus a country write stalled through HY.
    cif.cfg_valid = 1'b1; cif.cfg_addr = CFG_WALK; cif.cfg_data = 4'd12;
    step();
    cif.cfg_valid = 1'b0;
    pulse_ped();
    step();
    chk("ped2_hy", 32'(traffic_state), 32'(HY));
    cif.cfg_valid = 1'b1; cif.cfg_addr = CFG_COUNTRY; cif.cfg_data = 4'd9;
    chk("ready_low_hy", 32'(cif.cfg_ready), 32'd0);
    wait_phase("stall_to_cg", CG, 20);
    step();
    cif.cfg_valid = 1'b0;
    count_phase(CG, n); chk("walk12_cg_len", 32'(n + 1), 32'd13);

    // Emergency during CG, then HG held despite the car.
    car_sync = 1'b1;
    wait_phase("em_reach_cg", CG, 40);
    step(); step();
    emerg_req = 1'b1;
    step(); step();
    chk("em_cg_exit", 32'(traffic_state), 32'(CY));
    chk("em_walk_off", 32'(walk), 32'd0);
    count_phase(CY, n);
    repeat (15) step();
    chk("em_hold_hg", 32'(traffic_state), 32'(HG));

    // Emergency during HY returns to HG, then normal flow resumes.
    emerg_req = 1'b0;
    wait_phase("em2_reach_hy", HY, 20);
    emerg_req = 1'b1;
    count_phase(HY, n);
    chk("em_hy_to_hg", 32'(traffic_state), 32'(HG));
    emerg_req = 1'b0;
    wait_phase("resume_cg", CG, 30);
    count_phase(CG, n); chk("country9_cg_len", 32'(n), 32'd10);

    // Reset in the middle of a served CG.
    pulse_ped();
    wait_phase("rst_reach_cg", CG, 40);
    cif.cfg_valid = 1'b1; cif.cfg_addr = CFG_COUNTRY; cif.cfg_data = 4'd2;
    step();
    cif.cfg_valid = 1'b0;
    step();
    chk("walk_before_rst", 32'(walk), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_state", 32'(traffic_state), 32'(HG));
    chk("rst_rem5", 32'(remaining), 32'd5);
    chk("rst_walk", 32'(walk), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_phase("post_rst_cg", CG, 40);
    count_phase(CG, n); chk("post_rst_cg_len", 32'(n), 32'd9);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick     = ($urandom_range(0, 3) != 0);
      car_sync = ($urandom_range(0, 3) == 0);
      ped_req  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) emerg_req = ~emerg_req;
      cif.cfg_valid = ($urandom_range(0, 7) == 0);
      cif.cfg_addr  = 2'($urandom_range(0, 3));
      cif.cfg_data  = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
